// File: rtl/arm_mem_pkg.sv
// Shared types, default geometry and address checks for the MEM-stage data-memory initiator.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } mau_state_e;

  localparam int unsigned BaseAddrDefault   = 1024;
  localparam int unsigned DepthWordsDefault = 4096;
  localparam int unsigned TimeoutDefault    = 15;

  // Legal means word aligned and inside [base, base + 4*depth_words).
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth_words);
    logic [33:0] end_addr;
    end_addr = 34'(base) + (34'(depth_words) << 2);
    return (addr >= base) && (34'(addr) < end_addr) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and SRAM-side signals of the memory access unit, bundled with directional views.
interface mem_access_unit_if #(
  parameter int unsigned AddrWidth = 12
);
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic [31:0]          alu_result;
  logic [31:0]          val_rm;
  logic                 freeze;
  logic [31:0]          mem_result;
  logic                 err;
  logic                 sram_req;
  logic                 sram_we;
  logic [AddrWidth-1:0] sram_addr;
  logic [31:0]          sram_wdata;
  logic                 sram_ack;
  logic [31:0]          sram_rdata;

  modport master (
    input  mem_r_en, mem_w_en, alu_result, val_rm, sram_ack, sram_rdata,
    output freeze, mem_result, err, sram_req, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    output mem_r_en, mem_w_en, alu_result, val_rm, sram_ack, sram_rdata,
    input  freeze, mem_result, err, sram_req, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// Cycle counter bounding how long an SRAM request may wait for its acknowledge.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] count_q, count_d;

  assign expired = (count_q == CntW'(TIMEOUT - 1));

  // Saturates at the expiry value so the flag stays stable until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns pipeline loads/stores into held, word-indexed SRAM requests,
// freezes the pipeline while waiting, and flags illegal or timed-out accesses.
module mem_access_unit
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BaseAddrDefault,
  parameter int unsigned DEPTH_WORDS = DepthWordsDefault,
  parameter int unsigned TIMEOUT     = TimeoutDefault
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  mau_state_e state_q, state_d;

  logic          sram_req_q, sram_req_d;
  logic          sram_we_q, sram_we_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;
  logic [31:0]   mem_result_q, mem_result_d;
  logic          err_q, err_d;

  logic          req_present;
  logic          req_legal;
  logic [AW-1:0] word_idx;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          cnt_expired;

  assign req_present = bus.mem_r_en | bus.mem_w_en;
  assign req_legal   = addr_legal(bus.alu_result, BASE_ADDR, DEPTH_WORDS);
  assign word_idx    = AW'((bus.alu_result - BASE_ADDR) >> 2);

  assign cnt_clear  = (state_q == StIdle);
  assign cnt_enable = (state_q == StReq) && !bus.sram_ack;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  always_comb begin
    state_d      = state_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    mem_result_d = mem_result_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_present) begin
          if (req_legal) begin
            state_d      = StReq;
            sram_req_d   = 1'b1;
            sram_we_d    = bus.mem_w_en;
            sram_addr_d  = word_idx;
            sram_wdata_d = bus.val_rm;
            // Conflicting enables still issue the write but are reported.
            if (bus.mem_r_en && bus.mem_w_en) begin
              err_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StReq: begin
        // An ack on the expiry cycle wins over the timeout.
        if (bus.sram_ack) begin
          state_d    = StDone;
          sram_req_d = 1'b0;
          if (!sram_we_q) begin
            mem_result_d = bus.sram_rdata;
          end
        end else if (cnt_expired) begin
          state_d    = StDone;
          sram_req_d = 1'b0;
          err_d      = 1'b1;
          if (!sram_we_q) begin
            mem_result_d = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      mem_result_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      mem_result_q <= mem_result_d;
      err_q        <= err_d;
    end
  end

  assign bus.freeze     = rst & (((state_q == StIdle) & req_present & req_legal) |
                                 (state_q == StReq));
  assign bus.sram_req   = sram_req_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.mem_result = mem_result_q;
  assign bus.err        = err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-memory interface: sits in the MEM stage between the pipeline and a multi-cycle, handshaked data SRAM. It translates a pipeline load/store (byte address, store value) into a word-indexed memory request and holds the request until the memory acknowledges. It freezes the pipeline for the duration, captures load data, and flags illegal or timed-out accesses.

## Interface
- BASE_ADDR, 1024: byte address mapped to word 0.
- DEPTH_WORDS, 4096: number of 32-bit words; sram_addr width is clog2(DEPTH_WORDS) = 12.
- TIMEOUT, 15: maximum REQ cycles to wait for sram_ack before aborting.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- mem_r_en  in  1  pipeline load request.
- mem_w_en  in  1  pipeline store request.
- alu_result  in  32  byte address.
- val_rm  in  32  store data (signed).
- freeze  out  1  stall pipeline; combinational.
- mem_result  out  32  last completed load data, registered.
- err  out  1  sticky error flag, registered.
- sram_req  out  1  request valid, registered.
- sram_we  out  1  1 = write, 0 = read; valid with sram_req.
- sram_addr  out  12  word index = (alu_result − BASE_ADDR) >> 2.
- sram_wdata  out  32  store data.
- sram_ack  in  1  memory completion; one-cycle pulse.
- sram_rdata  in  32  read data; valid in the sram_ack cycle.

## Operation
- FSM states are IDLE, REQ and DONE.
- **IDLE**
  - A request is present when mem_r_en | mem_w_en.
  - Legal request: the address is in [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS) and alu_result[1:0] = 0. The unit latches the address index, val_rm and we = mem_w_en into sram_* registers, asserts sram_req at the edge, clears the timeout counter and goes to REQ.
  - Illegal address (range or alignment): no memory request, no freeze, err set at the next edge, state stays IDLE, and mem_result is unchanged.
  - mem_r_en and mem_w_en both high: treated as a write, err set.
- **REQ**
  - sram_req, sram_we, sram_addr and sram_wdata are held stable.
  - On sram_ack: drop sram_req; on a read, register sram_rdata into mem_result; go to DONE.
  - With no ack, the counter increments. When the counter reaches TIMEOUT−1 without an ack: drop sram_req, set err, write mem_result = 0 on a read, go to DONE.
- **DONE**
  - Lasts one cycle; the pipeline advances.
  - The request inputs still show the finished access and are ignored.
  - Unconditional transition to IDLE.
- freeze = (IDLE & legal request) | REQ; freeze = 0 in DONE.
- sram_ack is ignored in IDLE and DONE.
- The pipeline holds mem_r_en, mem_w_en, alu_result and val_rm stable while freeze = 1.
- Reset values: state IDLE, sram_req 0, sram_we 0, sram_addr 0, sram_wdata 0, mem_result 0, err 0, counter 0. freeze = 0 in reset because the state is IDLE and inputs are gated by rst.
- err clears only on reset.

## Timing
- The request is seen in cycle 0 (IDLE, freeze = 1).
- sram_req is high from cycle 1.
- If sram_ack arrives in cycle 1+k (k ≥ 0):
  - DONE is in cycle 2+k, with freeze = 0 and mem_result valid.
  - The next request is accepted in cycle 3+k.
- Minimum access occupies 3 cycles with 2 freeze cycles.
- Timeout: sram_req is high for exactly TIMEOUT cycles, then DONE follows.
- Reset asserted mid-REQ: at that edge sram_req drops to 0 and all outputs take their reset values. A later late sram_ack is ignored.
- An ack in the same cycle as the timeout edge counts as a success.

## Structure
- Package arm_mem_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - defaults for BASE_ADDR, DEPTH_WORDS and TIMEOUT;
  - the address-legality function (range and alignment check).
- One sub-module, mem_timeout_counter: clear, enable, expired = (count == TIMEOUT−1), with synchronous active-low reset.

## Test plan
- **Load, ack next cycle.** Memory word at 1032 = 0x12345678; load alu_result = 1032, ack in the first REQ cycle.
  - sram_addr = 2, sram_we = 0.
  - freeze high for 2 cycles, mem_result = 0x12345678 in DONE, err = 0.
- **Store, delayed ack.** Store val_rm = −5 to 1024, ack after 4 REQ cycles.
  - sram_req high for 5 cycles, sram_addr = 0, sram_wdata = 0xFFFFFFFB, sram_we = 1.
  - freeze high for 6 cycles; mem_result unchanged.
- **Illegal addresses.**
  - Load at 1026 (misaligned): no sram_req, freeze stays 0, err = 1 the next cycle.
  - Load at 1020 and at 1024 + 16384 (out of range): same response.
- **Timeout.** Load with sram_ack never asserted.
  - sram_req high for exactly 15 cycles, then DONE with mem_result = 0 and err = 1.
- **Reset mid-access.** rst = 0 in the second REQ cycle, then ack pulsed after release.
  - All outputs 0 after the edge, state IDLE, and the ack does not change mem_result.
- **Back-to-back and simultaneous.**
  - Store then load to the same address 1028 with immediate acks: the load returns the stored value, no restart in DONE.
  - mem_r_en = mem_w_en = 1: a write is issued and err = 1.
